// File: rtl/blink_arb_pkg.sv
// Shared definitions for the blink arbiter: FSM state encoding and default sizing.
package blink_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOn   = 2'd1,
      StOff  = 2'd2,
      StDone = 2'd3
   } blink_state_e;

   localparam int unsigned NReqDef = 3;
   localparam int unsigned CntWDef = 4;
   localparam int unsigned DivWDef = 13;

endpackage

// File: rtl/phase_prescaler.sv
// Phase-length prescaler: counts up from zero to a limit captured at load time.
module phase_prescaler
   import blink_arb_pkg::*;
#(
   parameter int unsigned DIV_W = DivWDef
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [DIV_W-1:0] limit_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic             tc_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] limit_q, limit_d;

   assign tc_o = (cnt_q == limit_q);

   // Counting stops at the limit, so the counter can never wrap.
   always_comb begin
      cnt_d   = cnt_q;
      limit_d = limit_q;
      if (load_i) begin
         limit_d = limit_i;
         cnt_d   = '0;
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         limit_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         limit_q <= limit_d;
      end
   end

endmodule

// File: rtl/blink_arbiter.sv
// Round-robin arbiter sharing one status LED; each granted requester gets a burst of N blinks.
module blink_arbiter
   import blink_arb_pkg::*;
#(
   parameter int unsigned NREQ  = NReqDef,
   parameter int unsigned CNT_W = CntWDef,
   parameter int unsigned DIV_W = DivWDef
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*CNT_W-1:0] blinks_i,
   input  logic [DIV_W-1:0]      tick_div_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  led_o
);

   localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

   blink_state_e     state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             led_q, led_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             pick_found;
   logic [IdxW-1:0]  pick_idx;
   logic [IdxW:0]    cand;
   logic [CNT_W-1:0] pick_cnt;
   logic [IdxW-1:0]  next_ptr;
   logic             psc_load, psc_clr, psc_en, psc_tc;

   // Priority search starting at the round-robin pointer, wrapping modulo NREQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + (IdxW + 1)'(i);
         if (cand >= (IdxW + 1)'(NREQ)) cand = cand - (IdxW + 1)'(NREQ);
         if (!pick_found && req_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IdxW-1:0];
         end
      end
   end

   assign pick_cnt = blinks_i[32'(pick_idx) * CNT_W +: CNT_W];
   assign next_ptr = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      psc_load = 1'b0;
      psc_clr  = 1'b0;
      psc_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               gnt_d    = NREQ'(1) << pick_idx;
               idx_d    = pick_idx;
               cnt_d    = pick_cnt;
               psc_load = 1'b1;
               state_d  = (pick_cnt == '0) ? StDone : StOn;
            end
         end
         StOn, StOff: begin
            psc_en = 1'b1;
            if (!req_i[idx_q]) begin
               // Abandoned: drop the grant silently but still move the pointer on.
               state_d = StIdle;
               gnt_d   = '0;
               ptr_d   = next_ptr;
            end else if (psc_tc) begin
               psc_clr = 1'b1;
               if (state_q == StOn) begin
                  state_d = StOff;
               end else begin
                  cnt_d   = cnt_q - 1'b1;
                  state_d = (cnt_q == CNT_W'(1)) ? StDone : StOn;
               end
            end
         end
         StDone: begin
            gnt_d   = '0;
            ptr_d   = next_ptr;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign led_d  = (state_d == StOn);
   assign busy_d = (state_d != StIdle);
   assign done_d = (state_d == StDone);

   phase_prescaler #(
      .DIV_W(DIV_W)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (psc_load),
      .limit_i(tick_div_i),
      .clr_i  (psc_clr),
      .en_i   (psc_en),
      .tc_o   (psc_tc)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign gnt_o  = gnt_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign led_o  = led_q;

endmodule

// File: tb/tb_blink_arbiter.sv
// Directed bench for blink_arbiter; observed word is {gnt, busy, done, led}.
module tb_blink_arbiter;

   localparam int unsigned NREQ  = 3;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DIV_W = 13;

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic [NREQ-1:0]       req_i;
   logic [NREQ*CNT_W-1:0] blinks_i;
   logic [DIV_W-1:0]      tick_div_i;
   logic [NREQ-1:0]       gnt_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  led_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   blink_arbiter #(
      .NREQ (NREQ),
      .CNT_W(CNT_W),
      .DIV_W(DIV_W)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .blinks_i  (blinks_i),
      .tick_div_i(tick_div_i),
      .gnt_o     (gnt_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .led_o     (led_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] obs();
      return {2'b00, gnt_o, busy_o, done_o, led_o};
   endfunction

   function automatic logic [7:0] mk(input logic [2:0] g, input logic b, input logic d,
                                     input logic l);
      return {2'b00, g, b, d, l};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      req_i  = '0;
      repeat (2) tick();
      rst_ni = 1'b1;
   endtask

   initial begin
      logic [2:0] g;
      int         ph;
      rst_ni     = 1'b0;
      req_i      = 3'b111;
      blinks_i   = {4'd1, 4'd1, 4'd1};
      tick_div_i = '0;

      // Reset held with all requests pending
      #1;
      check("rst_t0", obs(), 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_hold", obs(), 8'h00);
      end
      rst_ni = 1'b1;
      tick();
      check("rst_first_gnt", obs(), mk(3'b001, 1, 0, 1));

      // Single burst: requester 1, 3 blinks, P=5
      do_reset();
      blinks_i   = {4'd0, 4'd3, 4'd0};
      tick_div_i = 13'd4;
      req_i      = 3'b010;
      for (int c = 1; c <= 32; c++) begin
         tick();
         if (c <= 30) check("burst_phase", obs(), mk(3'b010, 1, 0, ((c - 1) / 5) % 2 == 0));
         else if (c == 31) begin
            check("burst_done", obs(), mk(3'b010, 1, 1, 0));
            req_i = 3'b000;
         end else check("burst_idle", obs(), 8'h00);
      end

      // Round-robin: all requesting, 1 blink each, P=1; 4 cycles per service
      do_reset();
      blinks_i   = {4'd1, 4'd1, 4'd1};
      tick_div_i = '0;
      req_i      = 3'b111;
      for (int c = 1; c <= 16; c++) begin
         tick();
         g  = 3'b001 << (((c - 1) / 4) % 3);
         ph = (c - 1) % 4;
         case (ph)
            0:       check("rr_on", obs(), mk(g, 1, 0, 1));
            1:       check("rr_off", obs(), mk(g, 1, 0, 0));
            2:       check("rr_done", obs(), mk(g, 1, 1, 0));
            default: check("rr_idle", obs(), 8'h00);
         endcase
         if (c == 15) req_i = 3'b000;
      end

      // Zero-count burst on requester 2
      do_reset();
      blinks_i = {4'd0, 4'd5, 4'd5};
      req_i    = 3'b100;
      tick();
      check("zero_done", obs(), mk(3'b100, 1, 1, 0));
      req_i = 3'b000;
      tick();
      check("zero_idle", obs(), 8'h00);

      // Abandon mid-ON, pending requester 1 picked up after one IDLE cycle
      do_reset();
      blinks_i   = {4'd0, 4'd2, 4'd4};
      tick_div_i = 13'd3;
      req_i      = 3'b011;
      tick();
      check("ab_on1", obs(), mk(3'b001, 1, 0, 1));
      tick();
      check("ab_on2", obs(), mk(3'b001, 1, 0, 1));
      req_i = 3'b010;
      tick();
      check("ab_idle", obs(), 8'h00);
      tick();
      check("ab_next_gnt", obs(), mk(3'b010, 1, 0, 1));
      req_i = 3'b000;
      tick();
      check("ab_next_drop", obs(), 8'h00);

      // Reconfiguration mid-burst ignored, then asynchronous reset mid-OFF
      do_reset();
      blinks_i   = {4'd0, 4'd0, 4'd2};
      tick_div_i = 13'd2;
      req_i      = 3'b001;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) begin
            tick_div_i = 13'd7;
            blinks_i   = {4'd0, 4'd0, 4'd15};
         end
         check("cfg_phase", obs(), mk(3'b001, 1, 0, ((c - 1) / 3) % 2 == 0));
      end
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_rst", obs(), 8'h00);
      tick();
      check("async_rst_hold", obs(), 8'h00);
      rst_ni = 1'b1;
      req_i  = 3'b000;
      tick();
      check("post_rst_idle", obs(), 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
